// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame gate family: FSM state encodings,
// default widths and the widths of the optional statistics counters.
// Optional feature macro used by cam_frame_gate: CAM_FRAME_GATE_STATS_EN.
package cam_pkg;

  localparam int CAM_DATA_W  = 24;
  localparam int CAM_DECIM_W = 4;
  localparam int CAM_FCNT_W  = 16;

  // Widths of the per-frame statistics (only used with the stats build)
  localparam int CAM_LINE_W  = 16;
  localparam int CAM_PIX_W   = 32;

  // One-hot frame gate states
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    PASS = 3'b010,
    SKIP = 3'b100
  } cam_state_t;

  // True when the given state forwards pixels downstream
  function automatic logic is_pass(input cam_state_t s);
    return (s == PASS);
  endfunction

endpackage

// File: rtl/cam_sof_det.sv
// Frame sync register chain and start-of-frame detector.
// o_sof is a combinational one-cycle pulse per rising edge of i_vsync.
// After reset the detector stays disarmed until i_vsync has been seen low,
// so a vsync that is already high when reset releases does not produce a
// start of frame until it falls and rises again.
module cam_sof_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_sof
);

  logic r_ff0;
  logic r_ff1;
  logic r_armed;

  // Two-flop chain on vsync plus the post-reset arming flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff0   <= 1'b0;
      r_ff1   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_ff0   <= i_vsync;
      r_ff1   <= r_ff0;
      r_armed <= r_armed | ~i_vsync;
    end
  end

  assign o_sof = r_ff0 & ~r_ff1 & r_armed;

endmodule

// File: rtl/cam_frame_gate.sv
// Camera frame gate: passes 1 frame out of (cfg_decim+1) while enabled.
// Enable and decimation are only sampled at a start of frame, so a frame in
// progress always completes with the decision taken at its start.
// Stream qualifier: s_data_valid / m_data_valid mark a pixel on the cycle
// they are high; there is no ready/backpressure, a pixel is consumed on the
// cycle its valid is high and m_data_valid follows s_data_valid one cycle
// later when the current frame is being passed.
// Optional feature macro: CAM_FRAME_GATE_STATS_EN adds line_cnt, pix_cnt and
// size_err for the last passed frame.
module cam_frame_gate
  import cam_pkg::*;
#(
  parameter int DATA_W  = CAM_DATA_W,
  parameter int DECIM_W = CAM_DECIM_W,
  parameter int FCNT_W  = CAM_FCNT_W
) (
  input  logic               axi_clk,
  input  logic               axi_rst_n,
  input  logic               axi_cam_en,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_data_valid,
  input  logic               s_hsync,
  input  logic               s_vsync,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_data_valid,
  output logic               m_hsync,
  output logic               m_vsync,
  output logic [FCNT_W-1:0]  frame_cnt,
  output logic [FCNT_W-1:0]  drop_cnt,
  output logic               busy,
  output cam_state_t         dbg_state
`ifdef CAM_FRAME_GATE_STATS_EN
  ,
  output logic [CAM_LINE_W-1:0] line_cnt,
  output logic [CAM_PIX_W-1:0]  pix_cnt,
  output logic                  size_err
`endif
);

  logic               w_sof;
  cam_state_t         w_next_state;
  cam_state_t         r_state;
  logic [DECIM_W-1:0] r_phase;
  logic [DATA_W-1:0]  r_m_data;
  logic               r_m_data_valid;
  logic               r_m_hsync;
  logic               r_m_vsync;
  logic [FCNT_W-1:0]  r_frame_cnt;
  logic [FCNT_W-1:0]  r_drop_cnt;

  cam_sof_det u_sof_det (
    .i_clk   (axi_clk),
    .i_rst_n (axi_rst_n),
    .i_vsync (s_vsync),
    .o_sof   (w_sof)
  );

  // Next-state decision, taken only on a start of frame
  always_comb begin
    w_next_state = r_state;
    if (w_sof) begin
      if (!axi_cam_en) begin
        w_next_state = IDLE;
      end else if (r_state == IDLE) begin
        w_next_state = PASS;
      end else if (r_phase == '0) begin
        w_next_state = PASS;
      end else begin
        w_next_state = SKIP;
      end
    end
  end

  // Gate FSM, decimation phase, counters and registered stream outputs
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_state        <= IDLE;
      r_phase        <= '0;
      r_m_data       <= '0;
      r_m_data_valid <= 1'b0;
      r_m_hsync      <= 1'b0;
      r_m_vsync      <= 1'b0;
      r_frame_cnt    <= '0;
      r_drop_cnt     <= '0;
    end else begin
      r_state        <= w_next_state;
      r_m_data       <= s_data;
      r_m_hsync      <= s_hsync;
      r_m_data_valid <= s_data_valid & is_pass(w_next_state);
      r_m_vsync      <= w_sof & is_pass(w_next_state);
      if (w_sof && axi_cam_en) begin
        // cfg_decim is picked up only here, so mid-frame changes wait
        if (w_next_state == PASS) begin
          r_phase <= cfg_decim;
        end else begin
          r_phase <= r_phase - DECIM_W'(1);
        end
      end
      if (w_sof && (w_next_state == PASS)) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
      if (w_sof && (w_next_state == SKIP)) begin
        r_drop_cnt <= r_drop_cnt + FCNT_W'(1);
      end
    end
  end

  assign m_data       = r_m_data;
  assign m_data_valid = r_m_data_valid;
  assign m_hsync      = r_m_hsync;
  assign m_vsync      = r_m_vsync;
  assign frame_cnt    = r_frame_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign busy         = is_pass(r_state);
  assign dbg_state    = r_state;

`ifdef CAM_FRAME_GATE_STATS_EN
  logic                  w_hs_rise;
  logic [CAM_LINE_W-1:0] r_line_run;
  logic [CAM_PIX_W-1:0]  r_pix_run;
  logic [CAM_LINE_W-1:0] r_line_cnt;
  logic [CAM_PIX_W-1:0]  r_pix_cnt;
  logic                  r_have_prev;
  logic                  r_size_err;

  // r_m_hsync holds last cycle's s_hsync, so this is the line start edge
  assign w_hs_rise = s_hsync & ~r_m_hsync;

  // Running line/pixel counts inside passed frames, latched at the next sof
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_line_run  <= '0;
      r_pix_run   <= '0;
      r_line_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_have_prev <= 1'b0;
      r_size_err  <= 1'b0;
    end else if (w_sof) begin
      if (r_state == PASS) begin
        r_line_cnt  <= r_line_run;
        r_pix_cnt   <= r_pix_run;
        r_have_prev <= 1'b1;
        if (r_have_prev && (r_pix_run != r_pix_cnt)) begin
          r_size_err <= 1'b1;
        end
      end
      r_line_run <= '0;
      r_pix_run  <= '0;
    end else if (is_pass(w_next_state)) begin
      r_line_run <= r_line_run + CAM_LINE_W'(w_hs_rise);
      r_pix_run  <= r_pix_run + CAM_PIX_W'(s_data_valid);
    end
  end

  assign line_cnt = r_line_cnt;
  assign pix_cnt  = r_pix_cnt;
  assign size_err = r_size_err;
`endif

endmodule

// File: doc/cam_frame_gate.md
CAM_FRAME_GATE -- requirements
Module: cam_frame_gate

Interface
REQ-001 Parameter DATA_W, default 24, pixel data width in bits.
REQ-002 Parameter DECIM_W, default 4, width of the frame-decimation setting.
REQ-003 Parameter FCNT_W, default 16, width of the frame counters.
REQ-004 axi_clk  in  1  single clock for all logic.
REQ-005 axi_rst_n  in  1  asynchronous active-low reset.
REQ-006 axi_cam_en  in  1  capture enable, level, sampled only at frame boundaries.
REQ-007 cfg_decim  in  DECIM_W  pass 1 frame out of (cfg_decim+1), sampled only at frame boundaries.
REQ-008 s_data  in  DATA_W  pixel data.
REQ-009 s_data_valid  in  1  pixel qualifier.
REQ-010 s_hsync  in  1  line sync, passed through.
REQ-011 s_vsync  in  1  frame sync, active-high, held during vertical blanking.
REQ-012 m_data  out  DATA_W  registered pixel data.
REQ-013 m_data_valid  out  1  pixel qualifier, asserted only inside passed frames.
REQ-014 m_hsync  out  1  registered s_hsync.
REQ-015 m_vsync  out  1  one-cycle start-of-frame pulse, only for passed frames.
REQ-016 frame_cnt  out  FCNT_W  count of passed frames.
REQ-017 drop_cnt  out  FCNT_W  count of frames skipped by decimation while enabled.
REQ-018 busy  out  1  high while state is PASS.

Function
REQ-019 s_vsync shall go through a 2-flop register chain (ff0, ff1); sof = ff0 & ~ff1, combinational, once per s_vsync rising edge.
REQ-020 The FSM shall have three one-hot states: IDLE, PASS and SKIP.
REQ-021 IDLE: on sof with axi_cam_en=1, go to PASS; load phase counter with cfg_decim.
REQ-022 PASS or SKIP: on sof with axi_cam_en=0, go to IDLE; without sof, hold the state.
REQ-023 PASS or SKIP: on sof with axi_cam_en=1, go to PASS if phase==0 (then reload phase=cfg_decim), else go to SKIP and decrement phase.
REQ-024 cfg_decim=0 shall pass every frame; the maximum value shall pass 1 of 2^DECIM_W frames.
REQ-025 Disabling shall take effect only at the next sof; a frame in progress completes unaffected.
REQ-026 Outputs shall have 1-cycle latency: m_data<=s_data every cycle, m_hsync<=s_hsync, m_data_valid<=s_data_valid & (next_state==PASS).
REQ-027 m_vsync shall be registered and pulse 1 cycle after any sof whose next_state is PASS.
REQ-028 frame_cnt shall increment on each PASS entry; drop_cnt shall increment on each SKIP entry; both wrap from all-ones to 0.
REQ-029 A change of cfg_decim mid-frame shall be ignored until the next PASS reload.

Reset
REQ-030 Assertion shall force, asynchronously: state IDLE, ff0=ff1=0, phase=0, counters 0, all outputs 0.
REQ-031 After deassertion, if s_vsync is already high, the first sof shall not occur until s_vsync falls and rises again.
REQ-032 Reset in the middle of a frame shall drop the remainder of that frame; no partial valid shall follow.

Configuration
REQ-033 With macro CAM_FRAME_GATE_STATS_EN defined, the block shall add outputs line_cnt (16 bits, s_hsync rising edges) and pix_cnt (32 bits, valid pixels), both for the last passed frame and latched at the next sof.
REQ-034 With CAM_FRAME_GATE_STATS_EN defined, it shall also add size_err, a sticky flag set when a passed frame's pix_cnt differs from the previous one and cleared by reset.
REQ-035 Without the macro, these ports and their logic shall be absent.

Structure
REQ-036 The shared package cam_pkg shall hold the state encodings (IDLE, PASS, SKIP) and the default DATA_W, DECIM_W and FCNT_W constants.
REQ-037 The vsync synchroniser/edge detector shall be the sub-module cam_sof_det, reused by the read-side blocks.

Verification
REQ-038 Scenario: en=1, cfg_decim=0, 3 frames of 4x8 pixels -> 96 m_data_valid, 3 m_vsync pulses, frame_cnt=3, drop_cnt=0.
REQ-039 Scenario: en=1, cfg_decim=2, 6 frames -> frames 1 and 4 pass, frame_cnt=2, drop_cnt=4, busy only in those frames.
REQ-040 Scenario: en drops mid frame 2 of 3 -> frame 2 fully passed, frame 3 blocked, state IDLE after sof 3.
REQ-041 Scenario: axi_rst_n pulsed low asynchronously mid-line -> outputs 0 within the same cycle, no valid until the next full sof.
REQ-042 Scenario: frame_cnt preset near wrap (FCNT_W=4, 17 frames) -> frame_cnt=1.
REQ-043 Scenario: with CAM_FRAME_GATE_STATS_EN, frames of 32 then 31 pixels -> pix_cnt=31, size_err=1.
